pcileech_button_ctl: RTL and testbench
======================================

PCILEECH_BUTTON_CTL -- requirements
Module: pcileech_button_ctl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a button change (10 ms at 100 MHz).
REQ-002 SHALL have parameter POR_CYCLES, default 64, power-on reset length in cycles.
REQ-003 SHALL have parameter RELOAD_CYCLES, default 500000000, debounced sw2 hold time that triggers config reload (5 s).
REQ-004 SHALL have parameter BLINK_BIT, default 24, tick bit that drives the power-on blink.
REQ-005 clk  input  1  system clock; all logic is in this single domain.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 user_sw1_n  input  1  raw asynchronous button 1, active-low.
REQ-008 user_sw2_n  input  1  raw asynchronous button 2 (reset button), active-low.
REQ-009 sys_rst  output  1  active-high system reset to the com, fifo and pcie blocks.
REQ-010 cfg_reload  output  1  single-cycle config-reload pulse.
REQ-011 tickcount64  output  64  free-running cycle counter since the last reset release.
REQ-012 led_pwronblink  output  1  LED invert signal for the com LED.
REQ-013 sw1_pressed  output  1  debounced button 1 level, 1 = pressed.

Function
REQ-014 SHALL pass each raw button through a 2-flop synchronizer before any other use; inputs are inverted there so 1 = pressed.
REQ-015 Per-button debouncer SHALL count consecutive cycles where synced input != debounced state, updating debounced state when count reaches DEBOUNCE_CYCLES-1; any match clears the count.
REQ-016 Debounce latency SHALL be 2 (sync) + DEBOUNCE_CYCLES cycles from a raw edge to the debounced edge; a glitch shorter than DEBOUNCE_CYCLES SHALL produce no change.
REQ-017 tickcount64 SHALL clear while debounced sw2 is pressed and SHALL increment by 1 each cycle otherwise; it SHALL saturate at all-ones rather than wrap.
REQ-018 sys_rst SHALL be 1 while debounced sw2 is pressed or tickcount64 < POR_CYCLES, and 0 otherwise; it SHALL be registered, lagging the condition by 1 cycle.
REQ-019 The hold FSM SHALL have states IDLE, HOLD, FIRED and RELEASE.
REQ-020 IDLE SHALL go to HOLD on debounced sw2 press and SHALL clear the 32-bit hold counter.
REQ-021 HOLD SHALL increment the hold counter each cycle, go to FIRED when the counter reaches RELOAD_CYCLES-1, and go to IDLE on release.
REQ-022 The HOLD-to-FIRED transition SHALL assert cfg_reload for exactly one cycle.
REQ-023 FIRED SHALL stay in FIRED while sw2 is held (no repeat pulse) and SHALL go to RELEASE on release.
REQ-024 RELEASE SHALL return to IDLE after one cycle.
REQ-025 A press and a release in the same cycle are impossible after debouncing; release in HOLD on the cycle the count would fire SHALL take precedence, giving no pulse.
REQ-026 led_pwronblink SHALL equal sw1_pressed XOR (tickcount64[BLINK_BIT] AND tickcount64[63:BLINK_BIT+3]==0), so the LED blinks only during the first 2^(BLINK_BIT+3) cycles.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst_n=0: synchronizers and debounced states SHALL be 0 (released), counters 0, FSM IDLE, sys_rst=1, cfg_reload=0, tickcount64=0, led_pwronblink=0, sw1_pressed=0.
REQ-029 Reset asserted mid-hold SHALL abort the hold with no cfg_reload pulse; after release the hold restarts from zero.
REQ-030 After rst_n rises, sys_rst SHALL stay 1 for POR_CYCLES+1 cycles, then fall.

Structure
REQ-031 FSM state enum and default parameter constants SHALL live in pcileech_header.svh / the shared package.
REQ-032 The debouncer SHALL be a sub-module, pcileech_debounce (synchronizer + counter), instantiated twice.
REQ-033 Target size SHALL be 150-250 lines of RTL total.

Verification (bench params DEBOUNCE_CYCLES=4, POR_CYCLES=8, RELOAD_CYCLES=20, BLINK_BIT=2)
REQ-034 Release rst_n at cycle 0 with buttons idle -> sys_rst=1 through cycle 8 and 0 from cycle 9; tickcount64 increments by 1 per cycle.
REQ-035 Pulse user_sw2_n low for 3 cycles -> debounced sw2 unchanged, sys_rst stays 0, tickcount64 continues.
REQ-036 Hold user_sw2_n low for 40 cycles -> sys_rst=1 from 7 cycles after the edge; exactly one cfg_reload pulse, 20 cycles after debounced press; none while the hold continues.
REQ-037 Hold sw2 for 15 cycles after debounce, then release -> no cfg_reload; FSM returns to IDLE; sys_rst stays 1 for 8 more cycles after tickcount64 restarts.
REQ-038 Drop rst_n for 1 cycle during a 10-cycle sw2 hold, then keep holding 30 cycles -> exactly one cfg_reload, 20 cycles after the re-debounced press.
REQ-039 Press sw1 with tickcount64 in the 0..31 window -> led_pwronblink = NOT tickcount64[2]; from tickcount64 >= 32 -> led_pwronblink = sw1_pressed.

Source files
------------

// File: rtl/pcileech_button_ctl_pkg.sv
// pcileech_button_ctl_pkg: hold-FSM states, default timing constants and blink helper
package pcileech_button_ctl_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, FIRED, RELEASE} hold_state_t;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_POR_CYCLES = 64;
  localparam int unsigned DEF_RELOAD_CYCLES = 500000000;
  localparam int unsigned DEF_BLINK_BIT = 24;
  function automatic logic blink_on(input logic [63:0] tick, input int unsigned bb);
    return tick[bb] && ((tick >> (bb + 3)) == 64'd0);
  endfunction
endpackage

// File: rtl/pcileech_debounce.sv
// pcileech_debounce: 2-flop synchronizer plus stable-count debouncer, output 1 = pressed
module pcileech_debounce
  import pcileech_button_ctl_pkg::*;
#(
  parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed
);
  localparam int CW = $clog2(CYCLES) + 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], ~btn_n};
      if (sync[1] == pressed) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        cnt <= '0;
        pressed <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/pcileech_button_ctl.sv
// pcileech_button_ctl: debounced buttons driving power-on/system reset, long-hold
// config reload, a saturating tick counter and the power-on LED blink
module pcileech_button_ctl
  import pcileech_button_ctl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned POR_CYCLES = DEF_POR_CYCLES,
  parameter int unsigned RELOAD_CYCLES = DEF_RELOAD_CYCLES,
  parameter int unsigned BLINK_BIT = DEF_BLINK_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        user_sw1_n,
  input  logic        user_sw2_n,
  output logic        sys_rst,
  output logic        cfg_reload,
  output logic [63:0] tickcount64,
  output logic        led_pwronblink,
  output logic        sw1_pressed
);
  logic sw1_db, sw2_db, fire;
  logic [63:0] tick_nxt;
  logic [31:0] hold_cnt;
  hold_state_t state, state_nxt;
  pcileech_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk(clk), .rst_n(rst_n), .btn_n(user_sw1_n), .pressed(sw1_db)
  );
  pcileech_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clk(clk), .rst_n(rst_n), .btn_n(user_sw2_n), .pressed(sw2_db)
  );
  always_comb begin
    tick_nxt = sw2_db ? 64'd0 : (&tickcount64 ? tickcount64 : tickcount64 + 64'd1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      hold_cnt <= (state == HOLD && sw2_db) ? hold_cnt + 32'd1 : 32'd0;
    end
  end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = sw2_db ? HOLD : IDLE;
      HOLD:    state_nxt = !sw2_db ? IDLE : (fire ? FIRED : HOLD);
      FIRED:   state_nxt = sw2_db ? FIRED : RELEASE;
      default: state_nxt = IDLE;
    endcase
  end
  // release on the terminal count wins because fire requires sw2 still held
  always_comb begin
    fire = state == HOLD && sw2_db && hold_cnt == 32'(RELOAD_CYCLES - 1);
  end
  // led is built from next-cycle tick and the same db1 sample that feeds sw1_pressed,
  // so the registered outputs stay mutually consistent
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tickcount64 <= '0;
      sys_rst <= 1'b1;
      cfg_reload <= 1'b0;
      sw1_pressed <= 1'b0;
      led_pwronblink <= 1'b0;
    end else begin
      tickcount64 <= tick_nxt;
      sys_rst <= sw2_db || tickcount64 < 64'(POR_CYCLES);
      cfg_reload <= fire;
      sw1_pressed <= sw1_db;
      led_pwronblink <= sw1_db ^ blink_on(tick_nxt, BLINK_BIT);
    end
  end
endmodule

// File: tb/tb_pcileech_button_ctl.sv
// tb_pcileech_button_ctl: directed scenarios plus random button/reset traffic,
// checked every cycle against a window-based behavioural model
module tb_pcileech_button_ctl;
  localparam int D = 4, P = 8, R = 20, B = 2;
  localparam logic [31:0] MASK = 32'((1 << D) - 1);
  logic clk = 1'b0, rst_n = 1'b0, sw1_n = 1'b1, sw2_n = 1'b1;
  logic sys_rst, cfg_reload, led_pwronblink, sw1_pressed;
  logic [63:0] tickcount64;
  int errors = 0, checks = 0;
  pcileech_button_ctl #(
    .DEBOUNCE_CYCLES(D), .POR_CYCLES(P), .RELOAD_CYCLES(R), .BLINK_BIT(B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .user_sw1_n(sw1_n), .user_sw2_n(sw2_n),
    .sys_rst(sys_rst), .cfg_reload(cfg_reload), .tickcount64(tickcount64),
    .led_pwronblink(led_pwronblink), .sw1_pressed(sw1_pressed)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic blink(input longint unsigned t);
    return ((t >> B) & 1) == 1 && t < (64'd1 << (B + 3));
  endfunction

  // Model: a button's debounced level flips once its last D synced samples all disagree
  logic [1:0] q1 = '0, q2 = '0;
  logic [31:0] h1 = '0, h2 = '0;
  logic db1 = 0, db2 = 0, nd1, nd2, m_sys = 1, m_cfg = 0, m_led = 0, m_sw1 = 0, started = 0;
  longint unsigned m_tick = 0;
  int run = 0;
  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      q1 = '0; q2 = '0; h1 = '0; h2 = '0; db1 = 0; db2 = 0;
      m_tick = 0; m_sys = 1; m_cfg = 0; m_led = 0; m_sw1 = 0; run = 0;
    end else begin
      h1 = {h1[30:0], q1[1]};
      h2 = {h2[30:0], q2[1]};
      nd1 = ((h1 & MASK) == (db1 ? 32'd0 : MASK)) ? ~db1 : db1;
      nd2 = ((h2 & MASK) == (db2 ? 32'd0 : MASK)) ? ~db2 : db2;
      q1 = {q1[0], ~sw1_n};
      q2 = {q2[0], ~sw2_n};
      m_sys = db2 || m_tick < P;
      run = db2 ? run + 1 : 0;
      m_cfg = (run == R + 1);
      m_tick = db2 ? 0 : (m_tick == 64'hFFFF_FFFF_FFFF_FFFF ? m_tick : m_tick + 1);
      m_sw1 = db1;
      m_led = db1 ^ blink(m_tick);
      db1 = nd1;
      db2 = nd2;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_sys_rst", sys_rst, m_sys);
      chk("m_cfg_reload", cfg_reload, m_cfg);
      chk("m_tick", tickcount64, m_tick);
      chk("m_led", led_pwronblink, m_led);
      chk("m_sw1", sw1_pressed, m_sw1);
    end
  end

  initial begin
    int first_rst, pulses, pulse_at, por_cnt;
    logic e;
    repeat (3) @(negedge clk);
    chk("rst_sys", sys_rst, 1);
    chk("rst_tick", tickcount64, 0);
    chk("rst_cfg", cfg_reload, 0);
    chk("rst_led", led_pwronblink, 0);
    chk("rst_sw1", sw1_pressed, 0);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("por_sys", sys_rst, i < 8);
      chk("por_tick", tickcount64, i + 1);
    end
    sw2_n = 0;
    repeat (3) @(negedge clk);
    sw2_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("glitch_sys", sys_rst, 0);
    end
    sw2_n = 0;
    first_rst = -1; pulses = 0; pulse_at = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (sys_rst && first_rst < 0) first_rst = j;
      if (cfg_reload) begin pulses++; pulse_at = j; end
    end
    sw2_n = 1;
    chk("hold_sys_at", first_rst, 6);
    chk("hold_pulses", pulses, 1);
    chk("hold_pulse_at", pulse_at, 26);
    repeat (40) @(negedge clk);
    sw2_n = 0;
    pulses = 0; por_cnt = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (j == 19) sw2_n = 1;
      if (cfg_reload) pulses++;
      if (j > 19 && sys_rst && tickcount64 > 0) por_cnt++;
    end
    chk("short_pulses", pulses, 0);
    chk("short_por", por_cnt, 8);
    sw2_n = 0;
    pulses = 0;
    repeat (10) begin @(negedge clk); if (cfg_reload) pulses++; end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    pulse_at = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (cfg_reload) begin pulses++; pulse_at = j; end
    end
    sw2_n = 1;
    chk("rsthold_pulses", pulses, 1);
    chk("rsthold_pulse_at", pulse_at, 26);
    repeat (20) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    sw1_n = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      e = (j >= 6) ^ ((((j + 1) >> 2) & 1) == 1 && j + 1 < 32);
      chk("blink_led", led_pwronblink, e);
    end
    sw1_n = 1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) sw1_n = ~sw1_n;
      if ($urandom_range(0, 11) == 0) sw2_n = ~sw2_n;
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
